// File: rtl/rd_scoreboard_pkg.sv
// Shared types for the destination-register scoreboard: sizing constants,
// the unit/priority encoding and the per-register entry layout.
package rd_scoreboard_pkg;

   localparam int SB_NUM_REGS = 32;
   localparam int SB_CNT_W    = 4;
   localparam int SB_UNIT_W   = 4;
   localparam int SB_IDX_W    = $clog2(SB_NUM_REGS);

   typedef enum logic [SB_UNIT_W-1:0] {
      P_DEFAULT  = 4'd0,
      P_FSQRT    = 4'd1,
      P_DIV      = 4'd2,
      P_FDIV     = 4'd3,
      P_R4       = 4'd4,
      P_FMUL     = 4'd5,
      P_FADD_SUB = 4'd6,
      P_MUL      = 4'd7
   } priority_t;

   typedef struct packed {
      logic      busy;
      priority_t owner;
   } sb_entry_t;

endpackage

// File: rtl/rd_scoreboard_bank.sv
// One register file's worth of scoreboard entries with a set port, a clear
// port and four combinational lookup ports; set wins over clear.
module sb_bank
   import rd_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = SB_NUM_REGS
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   set_en,
   input  logic [$clog2(NUM_REGS)-1:0]            set_idx,
   input  priority_t                              set_owner,
   input  logic                                   clr_en,
   input  logic [$clog2(NUM_REGS)-1:0]            clr_idx,
   input  logic [3:0][$clog2(NUM_REGS)-1:0]       lookup_idx,
   output sb_entry_t [3:0]                        lookup_entry,
   output logic [NUM_REGS-1:0]                    busy
);

   sb_entry_t entries [NUM_REGS];

   // The set is applied after the clear so a same-register collision keeps the new owner.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            entries[i] <= '{busy: 1'b0, owner: P_DEFAULT};
         end
      end else begin
         if (clr_en) begin
            entries[clr_idx].busy <= 1'b0;
         end
         if (set_en) begin
            entries[set_idx] <= '{busy: 1'b1, owner: set_owner};
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         busy[i] = entries[i].busy;
      end
      for (int k = 0; k < 4; k++) begin
         lookup_entry[k] = entries[lookup_idx[k]];
      end
   end

endmodule

// File: rtl/rd_scoreboard.sv
// Destination-register scoreboard: tracks in-flight writers for the int and
// FP files and flags RAW/WAW hazards for the instruction sitting in ID.
module rd_scoreboard
   import rd_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = SB_NUM_REGS,
   parameter int UNIT_W   = SB_UNIT_W,
   parameter int CNT_W    = SB_CNT_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          issue_valid,
   input  logic [$clog2(NUM_REGS)-1:0]   issue_rd,
   input  logic                          issue_rd_fp,
   input  logic [UNIT_W-1:0]             issue_unit,
   input  logic                          issue_cancel,
   input  logic [$clog2(NUM_REGS)-1:0]   id_rs1,
   input  logic [$clog2(NUM_REGS)-1:0]   id_rs2,
   input  logic [$clog2(NUM_REGS)-1:0]   id_rs3,
   input  logic                          id_rs1_fp,
   input  logic                          id_rs2_fp,
   input  logic                          id_rs3_fp,
   input  logic [2:0]                    id_rs_use,
   input  logic [$clog2(NUM_REGS)-1:0]   id_rd,
   input  logic                          id_rd_fp,
   input  logic                          id_rd_use,
   input  logic                          wb_valid,
   input  logic [$clog2(NUM_REGS)-1:0]   wb_rd,
   input  logic                          wb_rd_fp,
   input  logic [UNIT_W-1:0]             wb_unit,
   output logic                          rd_busy,
   output logic [NUM_REGS-1:0]           busy_int,
   output logic [NUM_REGS-1:0]           busy_fp,
   output logic [CNT_W-1:0]              inflight,
   output logic                          sb_idle,
   output logic                          sb_err
);

   localparam int IDX_W = $clog2(NUM_REGS);

   sb_entry_t [3:0]          int_lookup;
   sb_entry_t [3:0]          fp_lookup;
   sb_entry_t                wb_entry;
   logic [2:0][IDX_W-1:0]    src_idx;
   logic [2:0]               src_fp;
   logic [2:0]               src_busy;
   logic                     eff_issue, wb_x0, wb_match, clr_ok, wb_err;
   logic                     issue_busy, same_reg, issue_err, inc, dec, sat;
   logic                     raw, waw, id_rd_busy;
   logic [CNT_W-1:0]         cnt_q;
   logic                     err_q;

   sb_bank #(.NUM_REGS(NUM_REGS)) u_int_bank (
      .clk          (clk),
      .reset        (reset),
      .set_en       (eff_issue & ~issue_rd_fp),
      .set_idx      (issue_rd),
      .set_owner    (priority_t'(issue_unit)),
      .clr_en       (clr_ok & ~wb_rd_fp),
      .clr_idx      (wb_rd),
      .lookup_idx   ({wb_rd, id_rs3, id_rs2, id_rs1}),
      .lookup_entry (int_lookup),
      .busy         (busy_int)
   );

   sb_bank #(.NUM_REGS(NUM_REGS)) u_fp_bank (
      .clk          (clk),
      .reset        (reset),
      .set_en       (eff_issue & issue_rd_fp),
      .set_idx      (issue_rd),
      .set_owner    (priority_t'(issue_unit)),
      .clr_en       (clr_ok & wb_rd_fp),
      .clr_idx      (wb_rd),
      .lookup_idx   ({wb_rd, id_rs3, id_rs2, id_rs1}),
      .lookup_entry (fp_lookup),
      .busy         (busy_fp)
   );

   // An issue onto a register that is being retired this very cycle is a legal owner hand-over.
   always_comb begin
      eff_issue  = issue_valid & ~issue_cancel & ~((issue_rd == '0) & ~issue_rd_fp);
      wb_x0      = (wb_rd == '0) & ~wb_rd_fp;
      wb_entry   = wb_rd_fp ? fp_lookup[3] : int_lookup[3];
      wb_match   = wb_entry.busy & (wb_entry.owner == priority_t'(wb_unit));
      clr_ok     = wb_valid & ~wb_x0 & wb_match;
      wb_err     = wb_valid & ~wb_x0 & ~wb_match;
      issue_busy = issue_rd_fp ? busy_fp[issue_rd] : busy_int[issue_rd];
      same_reg   = (wb_rd == issue_rd) & (wb_rd_fp == issue_rd_fp);
      issue_err  = eff_issue & issue_busy & ~(clr_ok & same_reg);
      inc        = eff_issue & ~issue_err;
      dec        = clr_ok;
      sat        = inc & ~dec & (cnt_q == '1);
   end

   always_comb begin
      src_idx  = {id_rs3, id_rs2, id_rs1};
      src_fp   = {id_rs3_fp, id_rs2_fp, id_rs1_fp};
      src_busy = '0;
      for (int k = 0; k < 3; k++) begin
         src_busy[k] = (src_fp[k] ? fp_lookup[k].busy : int_lookup[k].busy)
                       & ~((src_idx[k] == '0) & ~src_fp[k]);
      end
      raw        = |(id_rs_use & src_busy);
      id_rd_busy = id_rd_fp ? busy_fp[id_rd] : busy_int[id_rd];
      waw        = id_rd_use & id_rd_busy & ~((id_rd == '0) & ~id_rd_fp);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | wb_err | issue_err | sat;
         if (inc && !dec && !sat) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign rd_busy  = raw | waw;
   assign inflight = cnt_q;
   assign sb_idle  = (cnt_q == '0);
   assign sb_err   = err_q;

endmodule

// File: tb/tb_rd_scoreboard.sv
// Directed bench for rd_scoreboard: the driver queues hand-computed expected
// outputs per cycle and an independent monitor pops and compares them.
module tb_rd_scoreboard;
   import rd_scoreboard_pkg::*;

   logic        clk;
   logic        reset;
   logic        issue_valid, issue_rd_fp, issue_cancel;
   logic [4:0]  issue_rd;
   logic [3:0]  issue_unit;
   logic [4:0]  id_rs1, id_rs2, id_rs3, id_rd;
   logic        id_rs1_fp, id_rs2_fp, id_rs3_fp, id_rd_fp, id_rd_use;
   logic [2:0]  id_rs_use;
   logic        wb_valid, wb_rd_fp;
   logic [4:0]  wb_rd;
   logic [3:0]  wb_unit;
   logic        rd_busy, sb_idle, sb_err;
   logic [31:0] busy_int, busy_fp;
   logic [3:0]  inflight;

   typedef struct {
      string       name;
      logic [31:0] rd_busy;
      logic [31:0] busy_int;
      logic [31:0] busy_fp;
      logic [31:0] inflight;
      logic [31:0] sb_err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   check_count = 0;
   int   pass_count  = 0;

   rd_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_rd_fp  (issue_rd_fp),
      .issue_unit   (issue_unit),
      .issue_cancel (issue_cancel),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs3       (id_rs3),
      .id_rs1_fp    (id_rs1_fp),
      .id_rs2_fp    (id_rs2_fp),
      .id_rs3_fp    (id_rs3_fp),
      .id_rs_use    (id_rs_use),
      .id_rd        (id_rd),
      .id_rd_fp     (id_rd_fp),
      .id_rd_use    (id_rd_use),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_rd_fp     (wb_rd_fp),
      .wb_unit      (wb_unit),
      .rd_busy      (rd_busy),
      .busy_int     (busy_int),
      .busy_fp      (busy_fp),
      .inflight     (inflight),
      .sb_idle      (sb_idle),
      .sb_err       (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clearInputs();
      reset = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_rd_fp = 1'b0;
      issue_unit = '0; issue_cancel = 1'b0;
      id_rs1 = '0; id_rs2 = '0; id_rs3 = '0;
      id_rs1_fp = 1'b0; id_rs2_fp = 1'b0; id_rs3_fp = 1'b0; id_rs_use = '0;
      id_rd = '0; id_rd_fp = 1'b0; id_rd_use = 1'b0;
      wb_valid = 1'b0; wb_rd = '0; wb_rd_fp = 1'b0; wb_unit = '0;
   endtask

   // Advances one cycle and returns to idle inputs just after the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   task automatic setIssue(input logic [4:0] rd, input logic fp, input priority_t unit);
      issue_valid = 1'b1; issue_rd = rd; issue_rd_fp = fp; issue_unit = unit;
   endtask

   task automatic setWb(input logic [4:0] rd, input logic fp, input priority_t unit);
      wb_valid = 1'b1; wb_rd = rd; wb_rd_fp = fp; wb_unit = unit;
   endtask

   task automatic setSrc1(input logic [4:0] rs, input logic fp);
      id_rs1 = rs; id_rs1_fp = fp; id_rs_use = 3'b001;
   endtask

   task automatic pushExpect(input string name, input int rb, input logic [31:0] bi,
                             input logic [31:0] bf, input int infl, input int err);
      exp_t e;
      e.name = name; e.rd_busy = 32'(rb); e.busy_int = bi; e.busy_fp = bf;
      e.inflight = 32'(infl); e.sb_err = 32'(err);
      exp_q.push_back(e);
   endtask

   task automatic compareField(input string name, input string what,
                               input logic [31:0] act, input logic [31:0] expv);
      check_count++;
      if (act !== expv) begin
         $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, what, act, expv);
      end else begin
         pass_count++;
      end
   endtask

   task automatic checkOutput(input exp_t e);
      compareField(e.name, "rd_busy",  32'(rd_busy),  e.rd_busy);
      compareField(e.name, "busy_int", busy_int,      e.busy_int);
      compareField(e.name, "busy_fp",  busy_fp,       e.busy_fp);
      compareField(e.name, "inflight", 32'(inflight), e.inflight);
      compareField(e.name, "sb_idle",  32'(sb_idle),  32'(e.inflight == 0));
      compareField(e.name, "sb_err",   32'(sb_err),   e.sb_err);
   endtask

   // Monitor: outputs are sampled mid-cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e);
         end
      end
   end

   initial begin
      clearInputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);

      applyStimulus(); pushExpect("reset", 0, 0, 0, 0, 0);

      applyStimulus(); setIssue(5, 0, P_DIV);      pushExpect("div_issue", 0, 0, 0, 0, 0);
      applyStimulus(); setSrc1(5, 0);              pushExpect("div_raw", 1, 32'h20, 0, 1, 0);
      applyStimulus(); setSrc1(5, 0); setWb(5, 0, P_DIV);
      pushExpect("div_wb_no_bypass", 1, 32'h20, 0, 1, 0);
      applyStimulus(); setSrc1(5, 0);              pushExpect("div_freed", 0, 0, 0, 0, 0);

      applyStimulus(); setIssue(3, 1, P_FDIV);     pushExpect("fdiv_issue", 0, 0, 0, 0, 0);
      applyStimulus(); id_rs3 = 5'd3; id_rs3_fp = 1'b1; id_rs_use = 3'b100;
      pushExpect("fdiv_raw_fp", 1, 0, 32'h8, 1, 0);
      applyStimulus(); id_rs3 = 5'd3; id_rs3_fp = 1'b0; id_rs_use = 3'b100;
      pushExpect("fdiv_int_alias", 0, 0, 32'h8, 1, 0);
      applyStimulus(); id_rd = 5'd3; id_rd_fp = 1'b1; id_rd_use = 1'b1; setWb(3, 1, P_FDIV);
      pushExpect("fdiv_waw", 1, 0, 32'h8, 1, 0);
      applyStimulus(); id_rd = 5'd3; id_rd_fp = 1'b1; id_rd_use = 1'b1;
      pushExpect("fdiv_freed", 0, 0, 0, 0, 0);

      applyStimulus(); setIssue(0, 0, P_MUL);      pushExpect("x0_issue", 0, 0, 0, 0, 0);
      applyStimulus(); setIssue(7, 0, P_MUL); issue_cancel = 1'b1;
      pushExpect("x0_untracked", 0, 0, 0, 0, 0);
      applyStimulus(); setWb(0, 0, P_MUL);         pushExpect("cancel_ignored", 0, 0, 0, 0, 0);

      applyStimulus(); setIssue(9, 0, P_FMUL);     pushExpect("x0_wb_no_err", 0, 0, 0, 0, 0);
      applyStimulus(); setWb(9, 0, P_FMUL); setIssue(9, 0, P_FADD_SUB);
      pushExpect("fmul_busy", 0, 32'h200, 0, 1, 0);
      applyStimulus(); setWb(9, 0, P_FADD_SUB);    pushExpect("handover", 0, 32'h200, 0, 1, 0);
      applyStimulus(); setWb(12, 0, P_MUL);        pushExpect("new_owner_wb", 0, 0, 0, 0, 0);

      applyStimulus(); reset = 1'b1;               pushExpect("wb_not_busy", 0, 0, 0, 0, 1);
      applyStimulus(); setIssue(12, 0, P_MUL);     pushExpect("reset_clears_err", 0, 0, 0, 0, 0);
      applyStimulus(); setWb(12, 0, P_DIV);        pushExpect("mul_busy", 0, 32'h1000, 0, 1, 0);
      applyStimulus(); setWb(12, 0, P_MUL);        pushExpect("owner_mismatch", 0, 32'h1000, 0, 1, 1);
      applyStimulus(); setIssue(1, 0, P_DIV);      pushExpect("err_sticky", 0, 0, 0, 0, 1);

      applyStimulus(); setIssue(2, 0, P_MUL);      pushExpect("flight_1", 0, 32'h2, 0, 1, 1);
      applyStimulus(); setIssue(1, 1, P_FDIV);     pushExpect("flight_2", 0, 32'h6, 0, 2, 1);
      applyStimulus(); setIssue(2, 1, P_FSQRT);    pushExpect("flight_3", 0, 32'h6, 32'h2, 3, 1);
      applyStimulus(); reset = 1'b1; setSrc1(1, 0);
      pushExpect("flight_4", 1, 32'h6, 32'h6, 4, 1);
      applyStimulus(); setSrc1(1, 0);              pushExpect("mid_reset", 0, 0, 0, 0, 0);

      applyStimulus(); setIssue(4, 0, P_DIV);      pushExpect("busy_issue_a", 0, 0, 0, 0, 0);
      applyStimulus(); setIssue(4, 0, P_MUL);      pushExpect("busy_issue_b", 0, 32'h10, 0, 1, 0);
      applyStimulus(); setWb(4, 0, P_MUL);         pushExpect("busy_issue_err", 0, 32'h10, 0, 1, 1);
      applyStimulus(); reset = 1'b1;               pushExpect("busy_issue_owner", 0, 0, 0, 0, 1);

      for (int i = 1; i <= 15; i++) begin
         applyStimulus(); setIssue(5'(i), 0, P_MUL);
      end
      applyStimulus(); setIssue(16, 0, P_MUL);     pushExpect("sat_15", 0, 32'h0000fffe, 0, 15, 0);
      applyStimulus();                             pushExpect("sat_err", 0, 32'h0001fffe, 0, 15, 1);
      applyStimulus();

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      if (exp_q.size() != 0) begin
         check_count++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      #1;
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
